// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; 2 clk latency,
// no backpressure. Reset value is configurable so idle-high lines stay idle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: data_valid 1 clk after the mid-stop-bit tick, no backpressure
// (host must take each strobe). Optional even parity bit under UART_RX_PARITY_EN.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_t          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_out_nxt;
  logic                 data_valid_nxt;
  logic                 frame_err_nxt;

`ifdef UART_RX_PARITY_EN
  logic par_pend, par_pend_nxt;
  logic parity_err_nxt;
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign busy = (state != IDLE);

  // Every counting step is gated by tick; a state entered on one tick starts
  // counting on the following tick, so no tick is counted twice.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    idx_nxt        = idx;
    shreg_nxt      = shreg;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    frame_err_nxt  = frame_err;
`ifdef UART_RX_PARITY_EN
    par_pend_nxt   = par_pend;
    parity_err_nxt = parity_err;
`endif
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            if (!rx_s) begin
              state_nxt = DATA;
              cnt_nxt   = '0;
              idx_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_END) begin
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            cnt_nxt   = '0;
            idx_nxt   = idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_END) begin
            par_pend_nxt = (^shreg) ^ rx_s;
            cnt_nxt      = '0;
            state_nxt    = STOP;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
          if (cnt == CNT_END) begin
            data_out_nxt   = shreg;
            frame_err_nxt  = !rx_s;
            data_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_nxt = par_pend;
`endif
            cnt_nxt        = '0;
            state_nxt      = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_pend   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_pend   <= par_pend_nxt;
      parity_err <= parity_err_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboarded bench for uart_rx_oversampled: frames are pushed as expected words when driven,
// a free-running monitor pops and compares on every data_valid strobe.
module tb_uart_rx_oversampled;

  localparam int DB      = 8;
  localparam int BIT_CLK = 64;  // div=4 ticks, 16 ticks per bit
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // ticks from start edge to the mid-stop sample of a frame
  localparam int FRAME_TICKS = 9 + 16 * (DB + 1 + (PAR ? 1 : 0));

  logic          clk;
  logic          rst;
  logic          tick;
  logic          rx;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_err;

  uart_rx_oversampled dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud generator with div=4: one tick every 4 clk.
  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (div == 3);
      div  = (div + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int gap);
    exp_t e;
    e.data = d;
    e.fe   = !stop_b;
    e.pe   = PAR && (good_par(d) != par_b);
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PAR) drive_bit(par_b);
    drive_bit(stop_b);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: every strobe must be single-cycle and match the oldest expected frame.
  initial begin
    logic prev_dv;
    exp_t e;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && data_valid) begin
        check("dv_single_cycle", {31'b0, prev_dv}, 32'd0);
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: actual data_out=%0h with no frame sent, required no strobe", data_out);
        end else begin
          e = q.pop_front();
          check("data_out", {24'b0, data_out}, {24'b0, e.data});
          check("frame_err", {31'b0, frame_err}, {31'b0, e.fe});
          check("parity_err", {31'b0, parity_err}, {31'b0, e.pe});
        end
      end
      prev_dv = rst && data_valid;
    end
  end

  initial begin
    logic [7:0] d;
    logic       sb;
    logic       pb;
    exp_t       brk;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    rx    = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_data_out", {24'b0, data_out}, 32'd0);
    check("rst_data_valid", {31'b0, data_valid}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_parity_err", {31'b0, parity_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    send_frame(8'hA5, 1'b1, good_par(8'hA5), 0);
    check("busy_after_a5", {31'b0, busy}, 32'd0);
    repeat (BIT_CLK) @(negedge clk);

    // Short low glitch: 4 ticks only.
    rx = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_glitch", {31'b0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (80) @(negedge clk);
    check("busy_after_glitch", {31'b0, busy}, 32'd0);

    send_frame(8'h3C, 1'b0, good_par(8'h3C), BIT_CLK);

    send_frame(8'h00, 1'b1, good_par(8'h00), 0);
    send_frame(8'hFF, 1'b1, good_par(8'hFF), BIT_CLK);

    // Reset in the middle of the 4th data bit.
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_data_out", {24'b0, data_out}, 32'd0);
    check("midrst_data_valid", {31'b0, data_valid}, 32'd0);
    check("midrst_frame_err", {31'b0, frame_err}, 32'd0);
    check("midrst_parity_err", {31'b0, parity_err}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b1, good_par(8'h5A), BIT_CLK);

    if (PAR) begin
      send_frame(8'h07, 1'b1, 1'b0, BIT_CLK);
      send_frame(8'h07, 1'b1, 1'b1, BIT_CLK);
    end

    // Break: line low long enough for two full frames, released before a third starts.
    brk.data = 8'h00;
    brk.fe   = 1'b1;
    brk.pe   = 1'b0;
    q.push_back(brk);
    q.push_back(brk);
    rx = 1'b0;
    repeat (4 * (2 * FRAME_TICKS + 4)) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);

    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      pb = ($urandom_range(0, 3) == 0) ? !good_par(d) : good_par(d);
      send_frame(d, sb, pb, sb ? int'($urandom_range(0, 100)) : BIT_CLK + int'($urandom_range(0, 100)));
    end

    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    repeat (2 * BIT_CLK) @(negedge clk);
    check("busy_idle_end", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
